conflict_batcher_mc: RTL and testbench

//  Next-generation conflict detection and batching stage for the SVM hardware scheduler.
//  - Takes NUM_CHANNELS AXI-Stream transaction sources and arbitrates them round-robin.
//  - Checks each granted transaction for RAW/WAW/WAR conflicts against the read/write masks

---
 rtl/conflict_batcher_mc_pkg.sv | 14 +
 rtl/conflict_batcher_mc_rr_arbiter.sv | 43 ++++
 rtl/conflict_batcher_mc.sv | 152 +++++++++++++++
 tb/tb_conflict_batcher_mc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conflict_batcher_mc_pkg.sv
// Shared types for the SVM scheduler batching stage: FSM states, conflict flags, ID width.
package svm_sched_pkg;

  localparam int OWNER_ID_W = 64;

  typedef enum logic {S_OPEN, S_CLOSE} batch_state_e;

  typedef struct packed {
    logic raw;
    logic waw;
    logic war;
  } conflict_t;

endpackage

// File: rtl/conflict_batcher_mc_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves past the granted index only when the consumer accepts the grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  localparam int unsigned N_U = N;

  logic [IW-1:0] ptr;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 0; i < N_U; i++) begin
      int unsigned idx;
      idx = (32'(ptr) + i) % N_U;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/conflict_batcher_mc.sv
// Conflict detection and batching stage: round-robin intake, RAW/WAW/WAR checks against the
// open batch's read/write masks, batch-tagged forwarding through a 1-deep output register.
module conflict_batcher_mc
  import svm_sched_pkg::*;
#(
  parameter int NUM_CHANNELS         = 4,
  parameter int MAX_DEPENDENCIES     = 256,
  parameter int MAX_BATCH_SIZE       = 8,
  parameter int BATCH_TIMEOUT_CYCLES = 100,
  parameter int BATCH_ID_WIDTH       = 8,
  parameter int DETECT_WAR           = 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CHANNELS-1:0]                  s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]                  s_axis_tready,
  input  logic [OWNER_ID_W*NUM_CHANNELS-1:0]       s_axis_tdata_owner_programID,
  input  logic [MAX_DEPENDENCIES*NUM_CHANNELS-1:0] s_axis_tdata_read_dependencies,
  input  logic [MAX_DEPENDENCIES*NUM_CHANNELS-1:0] s_axis_tdata_write_dependencies,
  output logic                                     m_axis_tvalid,
  input  logic                                     m_axis_tready,
  output logic [OWNER_ID_W-1:0]                    m_axis_tdata_owner_programID,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_read_dependencies,
  output logic [MAX_DEPENDENCIES-1:0]              m_axis_tdata_write_dependencies,
  output logic [BATCH_ID_WIDTH-1:0]                m_axis_tdata_batch_id,
  output logic [$clog2(NUM_CHANNELS)-1:0]          m_axis_tdata_channel,
  output logic                                     batch_completed,
  output logic [31:0]                              completed_batch_size,
  output logic [31:0]                              raw_conflicts,
  output logic [31:0]                              waw_conflicts,
  output logic [31:0]                              war_conflicts,
  output logic [31:0]                              transactions_processed,
  output logic [31:0]                              timeout_closes
);

  localparam int CH_W  = $clog2(NUM_CHANNELS);
  localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
  localparam int TMR_W = $clog2(BATCH_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BATCH_SIZE);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BATCH_TIMEOUT_CYCLES - 1);
  localparam bit WAR_BLOCKS = (DETECT_WAR != 0);

  batch_state_e                state;
  logic [MAX_DEPENDENCIES-1:0] batch_rd, batch_wr, sel_rd, sel_wr;
  logic [OWNER_ID_W-1:0]       sel_owner;
  logic [CNT_W-1:0]            count;
  logic [TMR_W-1:0]            timer;
  logic [BATCH_ID_WIDTH-1:0]   batch_id;
  logic [NUM_CHANNELS-1:0]     gnt_onehot;
  logic [CH_W-1:0]             gnt_idx;
  logic                        gnt_valid;
  conflict_t                   cf;
  logic blocking, out_free, full, timeout_hit, conflict_close, accept, close;

  rr_arbiter #(.N(NUM_CHANNELS)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (s_axis_tvalid),
    .advance     (accept),
    .grant       (gnt_onehot),
    .grant_idx   (gnt_idx),
    .grant_valid (gnt_valid)
  );

  always_comb begin
    sel_owner      = s_axis_tdata_owner_programID[gnt_idx*OWNER_ID_W +: OWNER_ID_W];
    sel_rd         = s_axis_tdata_read_dependencies[gnt_idx*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
    sel_wr         = s_axis_tdata_write_dependencies[gnt_idx*MAX_DEPENDENCIES +: MAX_DEPENDENCIES];
    cf.raw         = |(sel_rd & batch_wr);
    cf.waw         = |(sel_wr & batch_wr);
    cf.war         = |(sel_wr & batch_rd);
    blocking       = gnt_valid && (cf.raw || cf.waw || (cf.war && WAR_BLOCKS));
    out_free       = !m_axis_tvalid || m_axis_tready;
    full           = (count == CNT_MAX);
    timeout_hit    = (count != '0) && (timer == TMR_LAST);
    conflict_close = blocking && (count != '0);
    // Every close cause also vetoes accept, so a closing cycle never loads a transaction.
    accept         = (state == S_OPEN) && gnt_valid && !blocking && out_free && !full && !timeout_hit;
    close          = (state == S_OPEN) && (full || timeout_hit || conflict_close);
    s_axis_tready  = accept ? gnt_onehot : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                           <= S_OPEN;
      batch_rd                        <= '0;
      batch_wr                        <= '0;
      count                           <= '0;
      timer                           <= '0;
      batch_id                        <= '0;
      m_axis_tvalid                   <= 1'b0;
      m_axis_tdata_owner_programID    <= '0;
      m_axis_tdata_read_dependencies  <= '0;
      m_axis_tdata_write_dependencies <= '0;
      m_axis_tdata_batch_id           <= '0;
      m_axis_tdata_channel            <= '0;
      batch_completed                 <= 1'b0;
      completed_batch_size            <= '0;
      raw_conflicts                   <= '0;
      waw_conflicts                   <= '0;
      war_conflicts                   <= '0;
      transactions_processed          <= '0;
      timeout_closes                  <= '0;
    end else begin
      batch_completed <= 1'b0;
      if (accept) begin
        m_axis_tvalid                   <= 1'b1;
        m_axis_tdata_owner_programID    <= sel_owner;
        m_axis_tdata_read_dependencies  <= sel_rd;
        m_axis_tdata_write_dependencies <= sel_wr;
        m_axis_tdata_batch_id           <= batch_id;
        m_axis_tdata_channel            <= gnt_idx;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case (state)
        S_OPEN: begin
          timer <= (count != '0) ? timer + 1'b1 : '0;
          if (accept) begin
            batch_rd               <= batch_rd | sel_rd;
            batch_wr               <= batch_wr | sel_wr;
            count                  <= count + 1'b1;
            transactions_processed <= transactions_processed + 32'd1;
            // Only reachable with non-blocking WAR: it is tallied but still batched.
            if (cf.war) war_conflicts <= war_conflicts + 32'd1;
          end
          if (close) begin
            state                <= S_CLOSE;
            batch_completed      <= 1'b1;
            completed_batch_size <= 32'(count);
            if (timeout_hit) timeout_closes <= timeout_closes + 32'd1;
            if (conflict_close) begin
              if (cf.raw) raw_conflicts <= raw_conflicts + 32'd1;
              if (cf.waw) waw_conflicts <= waw_conflicts + 32'd1;
              if (cf.war) war_conflicts <= war_conflicts + 32'd1;
            end
          end
        end
        S_CLOSE: begin
          batch_rd <= '0;
          batch_wr <= '0;
          count    <= '0;
          timer    <= '0;
          batch_id <= batch_id + 1'b1;
          state    <= S_OPEN;
        end
        default: state <= S_OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_conflict_batcher_mc.sv
// Directed bench for conflict_batcher_mc: one blocking-WAR instance and one non-blocking-WAR
// instance share the same stimulus.
module tb_conflict_batcher_mc;

  localparam int NCH  = 4;
  localparam int DEP  = 256;
  localparam int BIDW = 8;
  localparam int CHW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]     s_tvalid, a_tready, b_tready;
  logic [64*NCH-1:0]  s_owner;
  logic [DEP*NCH-1:0] s_rd, s_wr;
  logic               m_tready;

  logic            a_mvalid, b_mvalid, a_done, b_done;
  logic [63:0]     a_owner, b_owner;
  logic [DEP-1:0]  a_rd, a_wr, b_rd, b_wr;
  logic [BIDW-1:0] a_bid, b_bid;
  logic [CHW-1:0]  a_ch, b_ch;
  logic [31:0]     a_size, a_raw, a_waw, a_war, a_proc, a_tmo;
  logic [31:0]     b_size, b_raw, b_waw, b_war, b_proc, b_tmo;

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;
  logic [31:0]    last_size = '0;
  logic [NCH-1:0] last_hs   = '0;
  logic           use_b     = 1'b0;

  always #5 clk = ~clk;

  conflict_batcher_mc #(
    .NUM_CHANNELS(NCH), .MAX_DEPENDENCIES(DEP), .MAX_BATCH_SIZE(8),
    .BATCH_TIMEOUT_CYCLES(100), .BATCH_ID_WIDTH(BIDW), .DETECT_WAR(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready),
    .s_axis_tdata_owner_programID(s_owner),
    .s_axis_tdata_read_dependencies(s_rd), .s_axis_tdata_write_dependencies(s_wr),
    .m_axis_tvalid(a_mvalid), .m_axis_tready(m_tready),
    .m_axis_tdata_owner_programID(a_owner),
    .m_axis_tdata_read_dependencies(a_rd), .m_axis_tdata_write_dependencies(a_wr),
    .m_axis_tdata_batch_id(a_bid), .m_axis_tdata_channel(a_ch),
    .batch_completed(a_done), .completed_batch_size(a_size),
    .raw_conflicts(a_raw), .waw_conflicts(a_waw), .war_conflicts(a_war),
    .transactions_processed(a_proc), .timeout_closes(a_tmo)
  );

  conflict_batcher_mc #(
    .NUM_CHANNELS(NCH), .MAX_DEPENDENCIES(DEP), .MAX_BATCH_SIZE(8),
    .BATCH_TIMEOUT_CYCLES(100), .BATCH_ID_WIDTH(BIDW), .DETECT_WAR(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready),
    .s_axis_tdata_owner_programID(s_owner),
    .s_axis_tdata_read_dependencies(s_rd), .s_axis_tdata_write_dependencies(s_wr),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(m_tready),
    .m_axis_tdata_owner_programID(b_owner),
    .m_axis_tdata_read_dependencies(b_rd), .m_axis_tdata_write_dependencies(b_wr),
    .m_axis_tdata_batch_id(b_bid), .m_axis_tdata_channel(b_ch),
    .batch_completed(b_done), .completed_batch_size(b_size),
    .raw_conflicts(b_raw), .waw_conflicts(b_waw), .war_conflicts(b_war),
    .transactions_processed(b_proc), .timeout_closes(b_tmo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DEP-1:0] bitv(input int b);
    bitv    = '0;
    bitv[b] = 1'b1;
  endfunction

  task automatic set_ch(input int c, input logic [63:0] owner, input logic [DEP-1:0] rd,
                        input logic [DEP-1:0] wr);
    s_owner[64*c +: 64] = owner;
    s_rd[DEP*c +: DEP]  = rd;
    s_wr[DEP*c +: DEP]  = wr;
  endtask

  // Called at a negedge; captures the input handshake just before the rising edge,
  // retires handshaken sources, and returns at the following negedge.
  task automatic tick();
    logic [NCH-1:0] rdy;
    #4;
    rdy     = use_b ? b_tready : a_tready;
    last_hs = s_tvalid & rdy;
    @(posedge clk);
    @(negedge clk);
    s_tvalid = s_tvalid & ~last_hs;
    if (a_done) begin
      pulses++;
      last_size = a_size;
    end
  endtask

  task automatic send(input int c, input logic [63:0] owner, input logic [DEP-1:0] rd,
                      input logic [DEP-1:0] wr);
    int n = 0;
    set_ch(c, owner, rd, wr);
    s_tvalid[c] = 1'b1;
    last_hs     = '0;
    while (!last_hs[c] && n < 20) begin
      tick();
      n++;
    end
    check("send_hs", 64'(last_hs[c]), 64'd1);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_owner  = '0;
    s_rd     = '0;
    s_wr     = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0, n;
    rst = 1'b1; s_tvalid = '0; s_owner = '0; s_rd = '0; s_wr = '0; m_tready = 1'b1;
    repeat (2) @(negedge clk);
    check("por_mvalid", 64'(a_mvalid), 64'd0);
    check("por_proc",   64'(a_proc),   64'd0);
    check("por_done",   64'(a_done),   64'd0);
    check("por_bid",    64'(a_bid),    64'd0);
    rst = 1'b0;

    // Round robin over four disjoint sources
    for (int c = 0; c < NCH; c++) set_ch(c, 64'(100 + c), bitv(2*c), bitv(2*c + 1));
    s_tvalid = '1;
    for (int i = 0; i < NCH; i++) begin
      tick();
      check("rr_valid", 64'(a_mvalid), 64'd1);
      check("rr_ch",    64'(a_ch),     64'(i));
      check("rr_owner", a_owner,       64'(100 + i));
      check("rr_bid",   64'(a_bid),    64'd0);
    end

    // Asynchronous reset mid-batch with the output register full
    rst = 1'b1;
    #1;
    check("arst_mvalid", 64'(a_mvalid), 64'd0);
    check("arst_proc",   64'(a_proc),   64'd0);
    check("arst_owner",  a_owner,       64'd0);
    check("arst_bid",    64'(a_bid),    64'd0);
    s_tvalid = '0;
    @(negedge clk);
    rst = 1'b0;

    // RAW: ch0 writes bit5, ch1 reads bit5
    set_ch(0, 64'hA, '0, bitv(5));
    set_ch(1, 64'hB, bitv(5), '0);
    s_tvalid = 4'b0011;
    tick();
    check("raw_first_owner", a_owner,     64'hA);
    check("raw_first_bid",   64'(a_bid),  64'd0);
    tick();
    check("raw_done",   64'(a_done),   64'd1);
    check("raw_size",   64'(a_size),   64'd1);
    check("raw_cnt",    64'(a_raw),    64'd1);
    check("raw_waw",    64'(a_waw),    64'd0);
    check("raw_mvalid", 64'(a_mvalid), 64'd0);
    tick();
    tick();
    check("raw_second_owner", a_owner,     64'hB);
    check("raw_second_bid",   64'(a_bid),  64'd1);
    check("raw_second_ch",    64'(a_ch),   64'd1);

    // Size limit: nine disjoint transactions on ch0
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 9; k++) begin
      send(0, 64'(32'h200 + k), bitv(2*k), bitv(2*k + 1));
      check("size_owner", a_owner,    64'(32'h200 + k));
      check("size_bid",   64'(a_bid), (k < 8) ? 64'd0 : 64'd1);
    end
    check("size_pulses", 64'(pulses - p0), 64'd1);
    check("size_closed", 64'(last_size),   64'd8);
    check("size_tmo",    64'(a_tmo),       64'd0);

    // Timeout: one transaction then idle
    do_reset();
    send(0, 64'h300, bitv(10), bitv(11));
    p0 = pulses;
    n  = 0;
    while (pulses == p0 && n < 200) begin
      tick();
      n++;
    end
    check("tmo_latency", 64'(n),         64'd100);
    check("tmo_closes",  64'(a_tmo),     64'd1);
    check("tmo_size",    64'(last_size), 64'd1);

    // Backpressure: output held, no accepts while stalled
    do_reset();
    m_tready = 1'b0;
    send(0, 64'h400, bitv(20), bitv(21));
    set_ch(1, 64'h401, bitv(22), bitv(23));
    s_tvalid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_owner",  a_owner,         64'h400);
      check("bp_mvalid", 64'(a_mvalid),   64'd1);
      check("bp_proc",   64'(a_proc),     64'd1);
      check("bp_tready", 64'(a_tready),   64'd0);
    end
    m_tready = 1'b1;
    tick();
    check("bp_release_owner", a_owner,     64'h401);
    check("bp_release_proc",  64'(a_proc), 64'd2);

    // WAR: ch0 reads bit7, ch1 writes bit7; blocking in dut_a, batched in dut_b
    do_reset();
    use_b = 1'b1;
    set_ch(0, 64'h11, bitv(7), '0);
    set_ch(1, 64'h22, '0, bitv(7));
    s_tvalid = 4'b0011;
    tick();
    tick();
    check("war_b_owner",  b_owner,        64'h22);
    check("war_b_ch",     64'(b_ch),      64'd1);
    check("war_b_mvalid", 64'(b_mvalid),  64'd1);
    check("war_b_bid",    64'(b_bid),     64'd0);
    check("war_b_cnt",    64'(b_war),     64'd1);
    check("war_b_raw",    64'(b_raw),     64'd0);
    check("war_b_proc",   64'(b_proc),    64'd2);
    check("war_b_done",   64'(b_done),    64'd0);
    check("war_a_cnt",    64'(a_war),     64'd1);
    check("war_a_done",   64'(a_done),    64'd1);
    check("war_a_proc",   64'(a_proc),    64'd1);
    use_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
